mips_cpu_load_unit: RTL and testbench
=====================================

// Module: mips_cpu_load_unit
// PURPOSE
//  Multi-cycle load unit between execute and the register file write port.
//  Accepts one load per handshake and issues an Avalon-style word read.
//  Extracts, extends or merges the addressed bytes and drives a one-cycle
//  register write (write_index/write_enable/write_data) into the register file.
// PARAMETERS
//  READ_LATENCY  1  cycles from accepted read (mem_read & !mem_waitrequest) to valid mem_readdata; legal 0..3
// PORTS
//  clk              in   1   rising-edge clock
//  reset            in   1   synchronous reset, ACTIVE-LOW (0 = reset)
//  req_valid        in   1   load request valid
//  req_ready        out  1   unit can accept request (state IDLE, reset=1)
//  req_opcode       in   6   0x20 LB, 0x21 LH, 0x22 LWL, 0x23 LW, 0x24 LBU, 0x25 LHU, 0x26 LWR
//  req_addr         in   32  effective byte address
//  req_rt_index     in   5   destination register
//  req_rt_data      in   32  current rt value (merge source for LWL/LWR)
//  mem_address      out  32  word-aligned read address ({addr[31:2],2'b00})
//  mem_read         out  1   read strobe, held until !mem_waitrequest
//  mem_byteenable   out  4   always 4'hF while mem_read=1, else 0
//  mem_waitrequest  in   1   memory stall
//  mem_readdata     in   32  read data, little-endian byte lanes
//  write_index      out  5   register file write index
//  write_enable     out  1   one-cycle register write strobe
//  write_data       out  32  value to write
//  addr_error       out  1   one-cycle pulse on misaligned LH/LHU/LW
//  busy             out  1   state != IDLE
// BEHAVIOUR
//  Reset (reset=0 at edge): state=IDLE; all outputs 0; req_ready=0 while reset=0;
//   reset mid-operation aborts: mem_read drops next edge, pending write discarded.
//  States: IDLE -> REQ -> DATA -> WB -> IDLE; IDLE -> ERR -> IDLE.
//  IDLE: req_ready=1; req_valid latches opcode/addr/rt_index/rt_data.
//   Misaligned (LH/LHU addr[0]=1; LW addr[1:0]!=0) -> ERR, no memory access.
//   Unknown opcode: treated as LW.
//  ERR: addr_error=1 for exactly one cycle, write_enable=0, then IDLE.
//  REQ: mem_read=1, address stable; stay while mem_waitrequest=1;
//   on !mem_waitrequest -> DATA (READ_LATENCY=0: capture readdata same cycle, -> WB).
//  DATA: count READ_LATENCY-1 further cycles, capture mem_readdata on last -> WB.
//  WB: write_enable=1 for one cycle with write_index/write_data; forced 0 if
//   write_index==0. Next cycle IDLE; back-to-back requests accepted there.
//  Min latency (READ_LATENCY=1, no wait): accept edge N, mem_read cycle N+1,
//   data captured cycle N+2, write_enable high cycle N+3.
//  Extraction, b=addr[1:0], W=captured word:
//   LB/LBU: W[8b+7:8b] sign/zero-extended; LH/LHU: W[16*addr[1]+15 -: 16] extended;
//   LW: W.
//   LWL: (W << 8*(3-b)) | (rt & (32'h00FFFFFF >> 8*b)).
//   LWR: (W >> 8*b) | (rt & ~(32'hFFFFFFFF >> 8*b)).
//  Inputs ignored outside IDLE; mem_readdata ignored outside capture cycle.
// CONFIGURATION
//  MIPS_LOAD_UNALIGNED_EN defined: LWL/LWR implemented as above, any alignment.
//  Not defined: 0x22/0x26 follow the ERR path (addr_error pulse, no read, no write).
// TESTING
//  1 LB addr=0x1003, W=0x80FF_1234 -> mem_address=0x1000, write_data=0xFFFFFF80, write_enable 1 cycle.
//  2 LHU addr=0x1002, W=0x8001_0000, waitrequest high 3 cycles -> mem_read held 4 cycles; write_data=0x00008001.
//  3 LW addr=0x1001 -> addr_error pulse 1 cycle, mem_read never asserts, write_enable stays 0.
//  4 LWL addr=0x1001, W=0xAABBCCDD, rt=0x11223344 -> 0xCCDD3344 (EN); addr_error (no EN).
//  5 LWR addr=0x1002, same W/rt -> 0x1122AABB (EN); LW rt_index=0 -> write_enable stays 0.
//  6 reset=0 during REQ with waitrequest=1 -> mem_read 0 next edge, no write; following LW completes normally.

Source files
------------

// File: rtl/mips_cpu_load_unit.sv
// mips_cpu_load_unit
//   Multi-cycle load unit sitting between execute and the register-file
//   write port. One load is accepted per handshake. The unit issues a single
//   word read on an Avalon-style master, extracts, extends or merges the
//   addressed bytes, and produces a one-cycle register write.
//
//   Configuration macro: MIPS_LOAD_UNALIGNED_EN
//     defined     - LWL (0x22) and LWR (0x26) merge bytes into rt, any alignment
//     not defined - LWL/LWR raise addr_error and perform no read and no write
//
// Parameters
//   READ_LATENCY    cycles from accepted read to valid mem_readdata (0..3)
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous reset, active low
//   req_valid       load request valid
//   req_ready       unit idle and out of reset, can take a request
//   req_opcode      6-bit MIPS load opcode
//   req_addr        effective byte address
//   req_rt_index    destination register
//   req_rt_data     current rt value, merge source for LWL/LWR
//   mem_address     word-aligned read address
//   mem_read        read strobe, held while mem_waitrequest is high
//   mem_byteenable  4'hF while mem_read is high, otherwise 0
//   mem_waitrequest memory stall
//   mem_readdata    read data, little-endian byte lanes
//   write_index     register-file write index
//   write_enable    one-cycle register write strobe (never for r0)
//   write_data      value written to the register file
//   addr_error      one-cycle pulse on a misaligned or unsupported load
//   busy            unit is not idle
module mips_cpu_load_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_rt_index,
  input  logic [31:0] req_rt_data,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [4:0]  write_index,
  output logic        write_enable,
  output logic [31:0] write_data,
  output logic        addr_error,
  output logic        busy
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;

  // Last DATA-cycle count value; the DATA state is never entered when the
  // read latency is zero, so the value only matters for latencies 1..3.
  localparam logic [1:0] LAST_CNT = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DATA,
    WB,
    ERR
  } state_t;

  state_t      state_reg;
  logic [5:0]  op_reg;
  logic [1:0]  addr_lo_reg;
  logic [4:0]  rt_index_reg;
  logic [31:0] rt_data_reg;
  logic [1:0]  lat_cnt_reg;
  logic        mem_read_reg;
  logic [31:0] mem_address_reg;
  logic [3:0]  mem_byteenable_reg;
  logic        write_enable_reg;
  logic [4:0]  write_index_reg;
  logic [31:0] write_data_reg;
  logic        addr_error_reg;
  logic [31:0] load_value;

  // Misaligned or unsupported loads go down the error path. Unknown opcodes
  // behave as LW, including its word-alignment check.
  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LB, OP_LBU: return 1'b0;
      OP_LH, OP_LHU: return a[0];
`ifdef MIPS_LOAD_UNALIGNED_EN
      OP_LWL, OP_LWR: return 1'b0;
`else
      OP_LWL, OP_LWR: return 1'b1;
`endif
      default: return (a != 2'b00);
    endcase
  endfunction

  // Byte extraction/merge on the captured word. LWL/LWR are always decoded
  // here; without the unaligned feature they simply never reach capture.
  function automatic logic [31:0] extract(input logic [5:0]  op,
                                          input logic [1:0]  a,
                                          input logic [31:0] w,
                                          input logic [31:0] rt);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel = w[{a, 3'b000} +: 8];
    half_sel = a[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:  return {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: return {24'h000000, byte_sel};
      OP_LH:  return {{16{half_sel[15]}}, half_sel};
      OP_LHU: return {16'h0000, half_sel};
      OP_LWL: return (w << {(2'd3 - a), 3'b000}) | (rt & (32'h00FFFFFF >> {a, 3'b000}));
      OP_LWR: return (w >> {a, 3'b000}) | (rt & ~(32'hFFFFFFFF >> {a, 3'b000}));
      default: return w;
    endcase
  endfunction

  always_comb begin
    load_value = extract(op_reg, addr_lo_reg, mem_readdata, rt_data_reg);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg          <= IDLE;
      op_reg             <= 6'd0;
      addr_lo_reg        <= 2'd0;
      rt_index_reg       <= 5'd0;
      rt_data_reg        <= 32'd0;
      lat_cnt_reg        <= 2'd0;
      mem_read_reg       <= 1'b0;
      mem_address_reg    <= 32'd0;
      mem_byteenable_reg <= 4'h0;
      write_enable_reg   <= 1'b0;
      write_index_reg    <= 5'd0;
      write_data_reg     <= 32'd0;
      addr_error_reg     <= 1'b0;
    end else begin
      // Strobes are single-cycle by default.
      write_enable_reg <= 1'b0;
      addr_error_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            op_reg       <= req_opcode;
            addr_lo_reg  <= req_addr[1:0];
            rt_index_reg <= req_rt_index;
            rt_data_reg  <= req_rt_data;
            if (misaligned(req_opcode, req_addr[1:0])) begin
              addr_error_reg <= 1'b1;
              state_reg      <= ERR;
            end else begin
              mem_read_reg       <= 1'b1;
              mem_byteenable_reg <= 4'hF;
              mem_address_reg    <= {req_addr[31:2], 2'b00};
              state_reg          <= REQ;
            end
          end
        end
        ERR: begin
          state_reg <= IDLE;
        end
        REQ: begin
          if (!mem_waitrequest) begin
            mem_read_reg       <= 1'b0;
            mem_byteenable_reg <= 4'h0;
            if (READ_LATENCY == 0) begin
              // Zero-latency memory: data is valid in the accept cycle.
              write_data_reg   <= load_value;
              write_index_reg  <= rt_index_reg;
              write_enable_reg <= (rt_index_reg != 5'd0);
              state_reg        <= WB;
            end else begin
              lat_cnt_reg <= 2'd0;
              state_reg   <= DATA;
            end
          end
        end
        DATA: begin
          if (lat_cnt_reg == LAST_CNT) begin
            write_data_reg   <= load_value;
            write_index_reg  <= rt_index_reg;
            write_enable_reg <= (rt_index_reg != 5'd0);
            state_reg        <= WB;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + 2'd1;
          end
        end
        WB: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Ready is gated by reset so nothing is accepted while reset is asserted.
  assign req_ready      = (state_reg == IDLE) && reset;
  assign busy           = (state_reg != IDLE);
  assign mem_read       = mem_read_reg;
  assign mem_address    = mem_address_reg;
  assign mem_byteenable = mem_byteenable_reg;
  assign write_index    = write_index_reg;
  assign write_enable   = write_enable_reg;
  assign write_data     = write_data_reg;
  assign addr_error     = addr_error_reg;

endmodule

// File: tb/tb_mips_cpu_load_unit.sv
// Testbench for mips_cpu_load_unit: directed cases plus randomized loads,
// checked every cycle against a timeline/byte-array model of the unit.
module tb_mips_cpu_load_unit;
  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_opcode = 6'd0;
  logic [31:0] req_addr = 32'd0;
  logic [4:0]  req_rt_index = 5'd0;
  logic [31:0] req_rt_data = 32'd0;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_readdata = 32'd0;
  logic [4:0]  write_index;
  logic        write_enable;
  logic [31:0] write_data;
  logic        addr_error;
  logic        busy;

  mips_cpu_load_unit #(.READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_rt_index(req_rt_index), .req_rt_data(req_rt_data),
    .mem_address(mem_address), .mem_read(mem_read), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .write_index(write_index), .write_enable(write_enable), .write_data(write_data),
    .addr_error(addr_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected timeline of the transaction in flight (cycle numbers count edges).
  typedef struct {
    logic        active;
    int          A;      // first cycle after the accept edge
    int          w;      // waitrequest cycles
    int          E;      // last busy cycle (write or error cycle)
    logic        err;
    logic        abort;
    logic [31:0] addr;
    logic [31:0] W;
    logic [31:0] data;
    logic [4:0]  idx;
    logic        lit_en;
    logic [31:0] lit;
  } txn_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [4:0]  idx;
    logic [31:0] rt;
    logic [31:0] W;
    int          w;
    int          abort_at;
    logic        lit_en;
    logic [31:0] lit;
    int          mr;
    int          we;
    int          ae;
  } dir_t;

  txn_t cur;
  int   cyc = 0;
  logic rst_at_edge = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   mr_count = 0;
  int   we_count = 0;
  int   ae_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Load semantics expressed on byte lanes.
  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] W, input logic [31:0] rt,
                                             output logic err);
    logic [7:0] wb[4];
    logic [7:0] rb[4];
    logic [7:0] ob[4];
    int b;
    b = int'(addr[1:0]);
    err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb[i] = W[8*i +: 8];
      rb[i] = rt[8*i +: 8];
      ob[i] = 8'h00;
    end
    case (op)
      6'h20, 6'h24: begin
        ob[0] = wb[b];
        for (int i = 1; i < 4; i++) ob[i] = (op == 6'h20 && wb[b][7]) ? 8'hFF : 8'h00;
      end
      6'h21, 6'h25: begin
        err = addr[0];
        if (!err) begin
          ob[0] = wb[b];
          ob[1] = wb[b+1];
          for (int i = 2; i < 4; i++) ob[i] = (op == 6'h21 && wb[b+1][7]) ? 8'hFF : 8'h00;
        end
      end
`ifdef MIPS_LOAD_UNALIGNED_EN
      6'h22: begin
        for (int j = 0; j < 4; j++) begin
          if (j >= 3 - b) ob[j] = wb[j-(3-b)];
          else ob[j] = rb[j];
        end
      end
      6'h26: begin
        for (int j = 0; j < 4; j++) begin
          if (j + b <= 3) ob[j] = wb[j+b];
          else ob[j] = rb[j];
        end
      end
`else
      6'h22, 6'h26: err = 1'b1;
`endif
      default: begin
        err = (b != 0);
        for (int i = 0; i < 4; i++) ob[i] = wb[i];
      end
    endcase
    return {ob[3], ob[2], ob[1], ob[0]};
  endfunction

  always @(posedge clk) begin
    rst_at_edge = reset;
    cyc++;
  end

  // Memory: waitrequest and data placement follow the expected timeline;
  // everything outside the read window is random.
  always @(posedge clk) begin
    #1;
    if (cur.active && !cur.err && cyc >= cur.A && cyc < cur.A + cur.w)
      mem_waitrequest = 1'b1;
    else if (cur.active && !cur.err && cyc == cur.A + cur.w)
      mem_waitrequest = 1'b0;
    else
      mem_waitrequest = 1'($urandom % 2);
    if (cur.active && !cur.err && cyc == cur.A + cur.w + RL)
      mem_readdata = cur.W;
    else
      mem_readdata = $urandom;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (!rst_at_edge) begin
        chk("rst_ready", 32'(req_ready), 32'(reset));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_byteen", 32'(mem_byteenable), 32'd0);
        chk("rst_mem_addr", mem_address, 32'd0);
        chk("rst_we", 32'(write_enable), 32'd0);
        chk("rst_widx", 32'(write_index), 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        chk("rst_addr_err", 32'(addr_error), 32'd0);
      end else begin
        logic in_busy, exp_rd, exp_ae, exp_we;
        in_busy = cur.active && cyc >= cur.A && cyc <= cur.E;
        exp_rd  = in_busy && !cur.err && cyc <= cur.A + cur.w;
        exp_ae  = in_busy && cur.err && cyc == cur.A;
        exp_we  = in_busy && !cur.err && !cur.abort && cur.idx != 5'd0 && cyc == cur.E;
        chk("busy", 32'(busy), 32'(in_busy));
        chk("req_ready", 32'(req_ready), 32'(reset && !in_busy));
        chk("mem_read", 32'(mem_read), 32'(exp_rd));
        chk("byteenable", 32'(mem_byteenable), exp_rd ? 32'hF : 32'h0);
        chk("addr_error", 32'(addr_error), 32'(exp_ae));
        chk("write_enable", 32'(write_enable), 32'(exp_we));
        if (exp_rd) chk("mem_address", mem_address, {cur.addr[31:2], 2'b00});
        if (exp_we) begin
          chk("write_index", 32'(write_index), 32'(cur.idx));
          chk("write_data", write_data, cur.data);
          if (cur.lit_en) chk("write_data_lit", write_data, cur.lit);
        end
      end
      if (mem_read) mr_count++;
      if (write_enable) we_count++;
      if (addr_error) ae_count++;
    end
  end

  task automatic run_txn(input dir_t d, input logic pin);
    logic        err;
    logic [31:0] data;
    data = model_load(d.op, d.addr, d.W, d.rt, err);
    cur.A      = cyc + 1;
    cur.w      = d.w;
    cur.err    = err;
    cur.abort  = 1'b0;
    cur.E      = err ? cur.A : cur.A + d.w + RL + 1;
    cur.addr   = d.addr;
    cur.W      = d.W;
    cur.data   = data;
    cur.idx    = d.idx;
    cur.lit_en = pin && d.lit_en;
    cur.lit    = d.lit;
    cur.active = 1'b1;
    req_valid    = 1'b1;
    req_opcode   = d.op;
    req_addr     = d.addr;
    req_rt_index = d.idx;
    req_rt_data  = d.rt;
    @(posedge clk); #1;
    mr_count = 0;
    we_count = 0;
    ae_count = 0;
    while (cyc <= cur.E) begin
      if (d.abort_at >= 0 && cyc == cur.A + d.abort_at) begin
        reset     = 1'b0;
        cur.abort = 1'b1;
        cur.E     = cyc;
      end
      // Inputs outside IDLE must be ignored.
      req_valid    = 1'($urandom % 2);
      req_opcode   = 6'($urandom);
      req_addr     = $urandom;
      req_rt_index = 5'($urandom);
      req_rt_data  = $urandom;
      @(posedge clk); #1;
    end
    reset     = 1'b1;
    req_valid = 1'b0;
    if (pin) begin
      chk("mem_read_cycles", 32'(mr_count), 32'(d.mr));
      chk("write_cycles", 32'(we_count), 32'(d.we));
      chk("addr_error_cycles", 32'(ae_count), 32'(d.ae));
    end
  endtask

  dir_t dirs[8];
  logic [5:0] ops[8];

  initial begin
    cur = '{default: '0};
    ops[0] = 6'h20; ops[1] = 6'h21; ops[2] = 6'h22; ops[3] = 6'h23;
    ops[4] = 6'h24; ops[5] = 6'h25; ops[6] = 6'h26; ops[7] = 6'h3F;
    //           op     addr          idx   rt            W             w  abort lit  lit_value     mr we ae
    dirs[0] = '{6'h20, 32'h0000_1003, 5'd5, 32'h0000_5555, 32'h80FF_1234, 0, -1, 1'b1, 32'hFFFF_FF80, 1, 1, 0};
    dirs[1] = '{6'h25, 32'h0000_1002, 5'd6, 32'h0000_5555, 32'h8001_0000, 3, -1, 1'b1, 32'h0000_8001, 4, 1, 0};
    dirs[2] = '{6'h23, 32'h0000_1001, 5'd7, 32'h0000_5555, 32'h1234_5678, 0, -1, 1'b0, 32'h0,         0, 0, 1};
`ifdef MIPS_LOAD_UNALIGNED_EN
    dirs[3] = '{6'h22, 32'h0000_1001, 5'd8, 32'h1122_3344, 32'hAABB_CCDD, 0, -1, 1'b1, 32'hCCDD_3344, 1, 1, 0};
    dirs[4] = '{6'h26, 32'h0000_1002, 5'd9, 32'h1122_3344, 32'hAABB_CCDD, 0, -1, 1'b1, 32'h1122_AABB, 1, 1, 0};
`else
    dirs[3] = '{6'h22, 32'h0000_1001, 5'd8, 32'h1122_3344, 32'hAABB_CCDD, 0, -1, 1'b0, 32'h0,         0, 0, 1};
    dirs[4] = '{6'h26, 32'h0000_1002, 5'd9, 32'h1122_3344, 32'hAABB_CCDD, 0, -1, 1'b0, 32'h0,         0, 0, 1};
`endif
    dirs[5] = '{6'h23, 32'h0000_1000, 5'd0, 32'h0000_5555, 32'hDEAD_BEEF, 0, -1, 1'b0, 32'h0,         1, 0, 0};
    dirs[6] = '{6'h23, 32'h0000_2000, 5'd3, 32'h0000_5555, 32'hCAFE_F00D, 6,  2, 1'b0, 32'h0,         3, 0, 0};
    dirs[7] = '{6'h23, 32'h0000_2004, 5'd4, 32'h0000_5555, 32'h1234_5678, 0, -1, 1'b1, 32'h1234_5678, 1, 1, 0};

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(dirs[i], 1'b1);

    for (int n = 0; n < 250; n++) begin
      dir_t d;
      d.op       = ops[$urandom_range(0, 7)];
      d.addr     = $urandom;
      d.idx      = 5'($urandom);
      d.rt       = $urandom;
      d.W        = $urandom;
      d.w        = $urandom_range(0, 3);
      d.abort_at = -1;
      d.lit_en   = 1'b0;
      d.lit      = 32'd0;
      d.mr       = 0;
      d.we       = 0;
      d.ae       = 0;
      run_txn(d, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
